// File: rtl/bilinear_scalar_core.sv
// Scalar bilinear downscaler: one output pixel per five-cycle COORD/ADDR/SAMPLE/INTERP/WRITE pass,
// reading a 2x2 neighbourhood through combinational read ports.
module bilinear_scalar_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIM_W  = 16,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  in_w,
    input  logic [DIM_W-1:0]  in_h,
    input  logic [DIM_W-1:0]  out_w,
    input  logic [DIM_W-1:0]  out_h,
    input  logic [DIM_W-1:0]  inv_scale_q,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    output logic [ADDR_W-1:0] rd_addr3,
    input  logic [DATA_W-1:0] rd_data0,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    input  logic [DATA_W-1:0] rd_data3,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int unsigned PW    = 2 * DIM_W;             // coordinate product width
    localparam int unsigned IW    = PW - FRAC_W;           // integer part of a coordinate
    localparam int unsigned WW    = FRAC_W + 1;            // weight width (0..256)
    localparam int unsigned ACC_W = 2 * WW + DATA_W;
    localparam int unsigned Q_W   = ACC_W - 2 * FRAC_W;

    typedef enum logic [2:0] {
        S_IDLE, S_COORD, S_ADDR, S_SAMPLE, S_INTERP, S_WRITE, S_DONE
    } state_t;

    state_t              state_q;
    logic                busy_q, done_q, wr_valid_q;
    logic [ADDR_W-1:0]   rd_addr0_q, rd_addr1_q, rd_addr2_q, rd_addr3_q, wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [DIM_W-1:0]    in_w_q, in_h_q, out_w_q, out_h_q, inv_q;
    logic [DIM_W-1:0]    ox_q, oy_q, x0_q, y0_q, x1_q, y1_q;
    logic [FRAC_W-1:0]   fx_q, fy_q;
    logic [DATA_W-1:0]   p00_q, p01_q, p10_q, p11_q;

    logic [PW-1:0]       sx_d, sy_d;
    logic [DIM_W-1:0]    x0_d, y0_d, x1_d, y1_d;
    logic [FRAC_W-1:0]   fx_d, fy_d;
    logic [ADDR_W-1:0]   a00_d, a01_d, a10_d, a11_d, wr_addr_d;
    logic [WW-1:0]       wx0, wx1, wy0, wy1;
    logic [ACC_W-1:0]    acc_d;
    logic [Q_W-1:0]      q_d;
    logic [DATA_W-1:0]   pix_d;
    logic                last_px;

    // Source coordinates, clamped so no neighbour address steps past the image edge
    always_comb begin
        sx_d = PW'(ox_q) * PW'(inv_q);
        sy_d = PW'(oy_q) * PW'(inv_q);
        if (sx_d[PW-1:FRAC_W] >= IW'(in_w_q)) begin
            x0_d = in_w_q - 1'b1;
            fx_d = '0;
        end else begin
            x0_d = sx_d[FRAC_W +: DIM_W];
            fx_d = sx_d[FRAC_W-1:0];
        end
        if (sy_d[PW-1:FRAC_W] >= IW'(in_h_q)) begin
            y0_d = in_h_q - 1'b1;
            fy_d = '0;
        end else begin
            y0_d = sy_d[FRAC_W +: DIM_W];
            fy_d = sy_d[FRAC_W-1:0];
        end
        x1_d = ((DIM_W+1)'(x0_d) + 1'b1 >= (DIM_W+1)'(in_w_q)) ? in_w_q - 1'b1 : x0_d + 1'b1;
        y1_d = ((DIM_W+1)'(y0_d) + 1'b1 >= (DIM_W+1)'(in_h_q)) ? in_h_q - 1'b1 : y0_d + 1'b1;
    end

    always_comb begin
        a00_d     = ADDR_W'(y0_q) * ADDR_W'(in_w_q) + ADDR_W'(x0_q);
        a01_d     = ADDR_W'(y0_q) * ADDR_W'(in_w_q) + ADDR_W'(x1_q);
        a10_d     = ADDR_W'(y1_q) * ADDR_W'(in_w_q) + ADDR_W'(x0_q);
        a11_d     = ADDR_W'(y1_q) * ADDR_W'(in_w_q) + ADDR_W'(x1_q);
        wr_addr_d = ADDR_W'(oy_q) * ADDR_W'(out_w_q) + ADDR_W'(ox_q);
        last_px   = (ox_q == out_w_q - 1'b1) && (oy_q == out_h_q - 1'b1);
    end

    always_comb begin
        wx1   = WW'(fx_q);
        wx0   = WW'(1 << FRAC_W) - wx1;
        wy1   = WW'(fy_q);
        wy0   = WW'(1 << FRAC_W) - wy1;
        acc_d = ACC_W'(wx0) * ACC_W'(wy0) * ACC_W'(p00_q)
              + ACC_W'(wx1) * ACC_W'(wy0) * ACC_W'(p01_q)
              + ACC_W'(wx0) * ACC_W'(wy1) * ACC_W'(p10_q)
              + ACC_W'(wx1) * ACC_W'(wy1) * ACC_W'(p11_q);
        q_d   = Q_W'((acc_d + ACC_W'(1 << (2*FRAC_W-1))) >> (2*FRAC_W));
        pix_d = (q_d > Q_W'({DATA_W{1'b1}})) ? '1 : q_d[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_addr0_q <= '0;
            rd_addr1_q <= '0;
            rd_addr2_q <= '0;
            rd_addr3_q <= '0;
            in_w_q     <= '0;
            in_h_q     <= '0;
            out_w_q    <= '0;
            out_h_q    <= '0;
            inv_q      <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            fx_q       <= '0;
            fy_q       <= '0;
            p00_q      <= '0;
            p01_q      <= '0;
            p10_q      <= '0;
            p11_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        in_w_q  <= in_w;
                        in_h_q  <= in_h;
                        out_w_q <= out_w;
                        out_h_q <= out_h;
                        inv_q   <= inv_scale_q;
                        ox_q    <= '0;
                        oy_q    <= '0;
                        if (out_w == '0 || out_h == '0) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_COORD;
                        end
                    end
                end
                S_COORD: begin
                    x0_q    <= x0_d;
                    y0_q    <= y0_d;
                    x1_q    <= x1_d;
                    y1_q    <= y1_d;
                    fx_q    <= fx_d;
                    fy_q    <= fy_d;
                    state_q <= S_ADDR;
                end
                S_ADDR: begin
                    rd_addr0_q <= a00_d;
                    rd_addr1_q <= a01_d;
                    rd_addr2_q <= a10_d;
                    rd_addr3_q <= a11_d;
                    state_q    <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    p00_q   <= rd_data0;
                    p01_q   <= rd_data1;
                    p10_q   <= rd_data2;
                    p11_q   <= rd_data3;
                    state_q <= S_INTERP;
                end
                S_INTERP: begin
                    wr_data_q  <= pix_d;
                    wr_addr_q  <= wr_addr_d;
                    wr_valid_q <= 1'b1;
                    state_q    <= S_WRITE;
                end
                S_WRITE: begin
                    wr_valid_q <= 1'b0;
                    if (last_px) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        if (ox_q == out_w_q - 1'b1) begin
                            ox_q <= '0;
                            oy_q <= oy_q + 1'b1;
                        end else begin
                            ox_q <= ox_q + 1'b1;
                        end
                        state_q <= S_COORD;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign rd_addr0 = rd_addr0_q;
    assign rd_addr1 = rd_addr1_q;
    assign rd_addr2 = rd_addr2_q;
    assign rd_addr3 = rd_addr3_q;

endmodule

// File: tb/tb_bilinear_scalar_core.sv
// Directed bench for bilinear_scalar_core: small frames with hand-computed pixels,
// plus reset, zero-size, edge-clamp, input-latching and mid-frame-reset cases.
module tb_bilinear_scalar_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] in_w = '0, in_h = '0, out_w = '0, out_h = '0, inv_scale_q = '0;
    logic        busy, done, wr_valid;
    logic [31:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3, wr_addr;
    logic [7:0]  rd_data0, rd_data1, rd_data2, rd_data3, wr_data;

    logic [7:0]  mem  [64];
    logic [7:0]  obuf [64];
    logic [31:0] ra0 [64];
    logic [31:0] ra1 [64];
    logic [31:0] ra3 [64];
    int          exp_px [64];
    int          n_checks = 0, n_fail = 0;
    int          wr_cnt = 0, done_cnt = 0, oob = 0;
    int unsigned rd_lim = 64;

    always #5 clk = ~clk;

    bilinear_scalar_core #(.DATA_W(8), .DIM_W(16), .ADDR_W(32), .FRAC_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_w(in_w), .in_h(in_h), .out_w(out_w), .out_h(out_h), .inv_scale_q(inv_scale_q),
        .busy(busy), .done(done),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
        .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    assign rd_data0 = (rd_addr0 < 64) ? mem[rd_addr0[5:0]] : 8'h00;
    assign rd_data1 = (rd_addr1 < 64) ? mem[rd_addr1[5:0]] : 8'h00;
    assign rd_data2 = (rd_addr2 < 64) ? mem[rd_addr2[5:0]] : 8'h00;
    assign rd_data3 = (rd_addr3 < 64) ? mem[rd_addr3[5:0]] : 8'h00;

    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt++;
            if (wr_addr < 64) begin
                obuf[wr_addr[5:0]] = wr_data;
                ra0[wr_addr[5:0]]  = rd_addr0;
                ra1[wr_addr[5:0]]  = rd_addr1;
                ra3[wr_addr[5:0]]  = rd_addr3;
            end
            if (rd_addr0 >= rd_lim || rd_addr1 >= rd_lim || rd_addr2 >= rd_lim || rd_addr3 >= rd_lim)
                oob++;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive a start pulse, then scramble the inputs to prove they were latched.
    task automatic launch(input int iw, input int ih, input int ow, input int oh, input int inv);
        for (int i = 0; i < 64; i++) obuf[i] = 8'hEE;
        wr_cnt = 0; done_cnt = 0; oob = 0;
        rd_lim = iw * ih;
        @(negedge clk);
        in_w = 16'(iw); in_h = 16'(ih); out_w = 16'(ow); out_h = 16'(oh); inv_scale_q = 16'(inv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_w = 16'd1; in_h = 16'd1; out_w = 16'd1; out_h = 16'd1; inv_scale_q = 16'd0;
    endtask

    task automatic run_frame(input string tag, input int iw, input int ih, input int ow,
                             input int oh, input int inv, input int max_lat);
        int cyc;
        int npx;
        npx = ow * oh;
        launch(iw, ih, ow, oh, inv);
        check({tag, "_busy"}, {31'd0, busy}, (npx != 0) ? 32'd1 : 32'd0);
        cyc = 1;
        while (!done && cyc < 400) begin
            start = (npx != 0 && cyc == 3);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        check({tag, "_latency_ok"}, {31'd0, (cyc <= max_lat)}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_writes"}, wr_cnt, npx);
        check({tag, "_oob_reads"}, oob, 32'd0);
        for (int i = 0; i < npx; i++)
            check($sformatf("%s_px%0d", tag, i), {24'd0, obuf[i]}, exp_px[i]);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int snap;
        for (int i = 0; i < 64; i++) mem[i] = 8'(10 * i);

        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        check("rst_wr_addr", wr_addr, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        check("rst_rd_addr0", rd_addr0, 32'd0);
        check("rst_rd_addr3", rd_addr3, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // 4x4 -> 2x2 at scale 2: picks img[0], img[2], img[8], img[10]
        exp_px[0] = 0; exp_px[1] = 20; exp_px[2] = 80; exp_px[3] = 100;
        run_frame("down2", 4, 4, 2, 2, 512, 29);

        // identity copy
        for (int i = 0; i < 16; i++) exp_px[i] = 10 * i;
        run_frame("ident", 4, 4, 4, 4, 256, 100);

        // half-pixel step between 0 and 255 rounds to 128
        mem[0] = 8'd0; mem[1] = 8'd255;
        exp_px[0] = 0; exp_px[1] = 128;
        run_frame("half", 2, 1, 2, 1, 128, 30);

        // source x beyond in_w-1 clamps to the last column with fx=0
        exp_px[0] = 0; exp_px[1] = 255; exp_px[2] = 255; exp_px[3] = 255;
        run_frame("xclamp", 2, 1, 4, 1, 256, 40);

        // empty output frame
        run_frame("zero", 4, 4, 0, 2, 256, 3);

        // 3x3 -> 2x2: ox=1 lands on the last column, x1 must equal x0
        for (int i = 0; i < 64; i++) mem[i] = 8'(10 * i);
        exp_px[0] = 0; exp_px[1] = 20; exp_px[2] = 60; exp_px[3] = 80;
        run_frame("edge", 3, 3, 2, 2, 512, 40);
        check("edge_rd0_ox1", ra0[1], 32'd2);
        check("edge_rd1_ox1", ra1[1], 32'd2);
        check("edge_rd3_last", ra3[3], 32'd8);

        // reset in the middle of a frame
        launch(4, 4, 4, 4, 256);
        repeat (30) @(negedge clk);
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        check("mid_rst_wr_addr", wr_addr, 32'd0);
        check("mid_rst_rd_addr0", rd_addr0, 32'd0);
        rst = 1'b0;
        snap = wr_cnt;
        repeat (60) @(negedge clk);
        check("mid_no_more_writes", wr_cnt, snap);
        check("mid_no_done", done_cnt, 32'd0);
        check("mid_idle_busy", {31'd0, busy}, 32'd0);

        exp_px[0] = 0; exp_px[1] = 20; exp_px[2] = 80; exp_px[3] = 100;
        run_frame("after_rst", 4, 4, 2, 2, 512, 29);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
